// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the VGA pattern generator.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_WHITE = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_t;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned BAR_IDX_W = 3;
    localparam logic [BAR_IDX_W-1:0] BAR_IDX_MAX = '1;

    function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic bit_at(input logic [31:0] val, input int unsigned idx);
        return val[idx[4:0]];
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, h/v counters and combinational sync/active decode of the current position.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned SYNC_POL = 0,
    localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned H_W     = $clog2(H_TOTAL),
    localparam int unsigned V_W     = $clog2(V_TOTAL)
) (
    input  logic           CLK_50,
    input  logic           RST,
    output logic           pe_c,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           h_sync_c,
    output logic           v_sync_c,
    output logic           active_c,
    output logic           origin_c,
    output logic           frame_wrap_c
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] div;
    logic             h_last_c;
    logic             v_last_c;
    logic             h_in_sync_c;
    logic             v_in_sync_c;

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div <= pe_c ? '0 : div + DIV_W'(1);
            if (pe_c) begin
                if (h_last_c) begin
                    h_cnt <= '0;
                    v_cnt <= v_last_c ? '0 : v_cnt + V_W'(1);
                end else begin
                    h_cnt <= h_cnt + H_W'(1);
                end
            end
        end
    end

    // Decodes are done at 32 bits so a zero back porch cannot alias the sync end onto count 0.
    assign pe_c         = (32'(div) == CLK_DIV - 1);
    assign h_last_c     = (32'(h_cnt) == H_TOTAL - 1);
    assign v_last_c     = (32'(v_cnt) == V_TOTAL - 1);
    assign h_in_sync_c  = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign v_in_sync_c  = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    assign h_sync_c     = h_in_sync_c ? SYNC_ACT : ~SYNC_ACT;
    assign v_sync_c     = v_in_sync_c ? SYNC_ACT : ~SYNC_ACT;
    assign active_c     = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign origin_c     = (h_cnt == '0) && (v_cnt == '0);
    assign frame_wrap_c = pe_c && h_last_c && v_last_c;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus four switch-selected test patterns; VGA_PATTERN_SCROLL_EN adds per-frame horizontal scroll.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned SYNC_POL  = 0,
    parameter int unsigned R_W       = 3,
    parameter int unsigned G_W       = 3,
    parameter int unsigned B_W       = 2,
    parameter int unsigned BAR_W     = 80,
    parameter int unsigned CHK_SHIFT = 5
) (
    input  logic           CLK_50,
    input  logic           RST,
    input  logic [3:0]     SW,
    output logic [7:0]     LED,
    output logic [R_W-1:0] RED,
    output logic [G_W-1:0] GREEN,
    output logic [B_W-1:0] BLUE,
    output logic           h_sync,
    output logic           v_sync,
    output logic           frame_start,
    output logic           in_display
);

    localparam int unsigned H_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_W      = $clog2(H_TOTAL);
    localparam int unsigned V_W      = $clog2(V_TOTAL);
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    logic                 pe_c, h_sync_c, v_sync_c, active_c, origin_c, frame_wrap_c;
    logic [H_W-1:0]       h_cnt;
    logic [V_W-1:0]       v_cnt;
    mode_t                mode_q, mode_c;
    logic                 inv_q, inv_c, frz_q;
    logic [15:0]          frame_cnt;
    logic [BAR_IDX_W-1:0] bar_c;
    logic [31:0]          x_c;
    logic                 chk_c;
    logic [R_W-1:0]       ramp_c, r_c;
    logic [G_W-1:0]       g_c;
    logic [B_W-1:0]       b_c;
    logic                 unused_frame_hi;

    vga_timing #(
        .CLK_DIV (CLK_DIV),  .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(SYNC_POL)
    ) u_timing (
        .CLK_50      (CLK_50),
        .RST         (RST),
        .pe_c        (pe_c),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_sync_c    (h_sync_c),
        .v_sync_c    (v_sync_c),
        .active_c    (active_c),
        .origin_c    (origin_c),
        .frame_wrap_c(frame_wrap_c)
    );

    // Pixel (0,0) already uses the switch value being latched, so a new frame starts in the new mode.
    assign mode_c = origin_c ? mode_t'(SW[1:0]) : mode_q;
    assign inv_c  = origin_c ? SW[2] : inv_q;

`ifdef VGA_PATTERN_SCROLL_EN
    assign x_c   = (32'(h_cnt) + 32'(frame_cnt[7:0])) % 32'(H_ACTIVE);
    assign bar_c = (x_c / 32'(BAR_W) > 32'(BAR_IDX_MAX)) ? BAR_IDX_MAX : BAR_IDX_W'(x_c / 32'(BAR_W));
`else
    localparam int unsigned BP_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [BP_W-1:0]      bar_pix;
    logic [BAR_IDX_W-1:0] bar_q;

    // Bar index tracks h_cnt: 0 at the start of every line, saturating at the last index.
    always_ff @(posedge CLK_50) begin
        if (RST) begin
            bar_pix <= '0;
            bar_q   <= '0;
        end else if (pe_c) begin
            if (32'(h_cnt) == H_TOTAL - 1) begin
                bar_pix <= '0;
                bar_q   <= '0;
            end else if (32'(bar_pix) == BAR_W - 1) begin
                bar_pix <= '0;
                if (bar_q != BAR_IDX_MAX) bar_q <= bar_q + BAR_IDX_W'(1);
            end else begin
                bar_pix <= bar_pix + BP_W'(1);
            end
        end
    end

    assign x_c   = 32'(h_cnt);
    assign bar_c = bar_q;
`endif

    if (R_W >= BAR_IDX_W) begin : g_ramp_ext
        assign ramp_c = R_W'(bar_c);
    end else begin : g_ramp_trunc
        assign ramp_c = bar_c[BAR_IDX_W-1 -: R_W];
    end

    assign chk_c = bit_at(x_c, CHK_SHIFT) ^ bit_at(32'(v_cnt), CHK_SHIFT);

    // Pattern select, optional inversion, then blanking outside the active area.
    always_comb begin
        r_c = '0;
        g_c = '0;
        b_c = '0;
        case (mode_c)
            MODE_WHITE: begin
                r_c = '1;
                g_c = '1;
                b_c = '1;
            end
            MODE_RAMP:  r_c = ramp_c;
            MODE_BARS: begin
                r_c = {R_W{bar_c[2]}};
                g_c = {G_W{bar_c[1]}};
                b_c = {B_W{bar_c[0]}};
            end
            MODE_CHECK: begin
                r_c = {R_W{chk_c}};
                g_c = {G_W{chk_c}};
                b_c = {B_W{chk_c}};
            end
            default: ;
        endcase
        if (inv_c) begin
            r_c = ~r_c;
            g_c = ~g_c;
            b_c = ~b_c;
        end
        if (!active_c) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            RED         <= '0;
            GREEN       <= '0;
            BLUE        <= '0;
            h_sync      <= ~SYNC_ACT;
            v_sync      <= ~SYNC_ACT;
            in_display  <= 1'b0;
            frame_start <= 1'b0;
            mode_q      <= MODE_WHITE;
            inv_q       <= 1'b0;
            frz_q       <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_start <= pe_c && origin_c;
            if (pe_c) begin
                RED        <= r_c;
                GREEN      <= g_c;
                BLUE       <= b_c;
                h_sync     <= h_sync_c;
                v_sync     <= v_sync_c;
                in_display <= active_c;
                if (origin_c) begin
                    mode_q <= mode_t'(SW[1:0]);
                    inv_q  <= SW[2];
                    frz_q  <= SW[3];
                end
                if (frame_wrap_c && !frz_q) frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign LED             = frame_cnt[7:0];
    assign unused_frame_hi = ^frame_cnt[15:8];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: default-timing sync checks plus a tiny-timing instance for patterns, latching, freeze and reset.
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_d, rst_s;
    logic [3:0] sw_d, sw_s;
    logic [7:0] led_d, led_s;
    logic [2:0] red_d, grn_d, red_s, grn_s;
    logic [1:0] blu_d, blu_s;
    logic       hs_d, vs_d, fs_d, de_d, hs_s, vs_s, fs_s, de_s;

    int         n_chk, n_bad, p, fcnt;
    logic [1:0] mode_l;
    logic       inv_l, frz_l;

    // Colour-bar line for the small instance, packed {R[2:0],G[2:0],B[1:0]}, indexed by pixel x.
    logic [7:0] bars_tab [8] = '{8'h00, 8'h00, 8'h03, 8'h03, 8'h1C, 8'h1C, 8'h1F, 8'h1F};

    always #5 clk = ~clk;

    vga_pattern_gen dut_d (
        .CLK_50(clk), .RST(rst_d), .SW(sw_d), .LED(led_d), .RED(red_d), .GREEN(grn_d), .BLUE(blu_d),
        .h_sync(hs_d), .v_sync(vs_d), .frame_start(fs_d), .in_display(de_d)
    );

    vga_pattern_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .BAR_W(2), .CHK_SHIFT(1)
    ) dut_s (
        .CLK_50(clk), .RST(rst_s), .SW(sw_s), .LED(led_s), .RED(red_s), .GREEN(grn_s), .BLUE(blu_s),
        .h_sync(hs_s), .v_sync(vs_s), .frame_start(fs_s), .in_display(de_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_rgb(input int h, input int v);
        int         x;
        logic [7:0] c;
        logic [2:0] b;
        if (h >= 8 || v >= 4) return 8'h00;
        x = h;
`ifdef VGA_PATTERN_SCROLL_EN
        x = (h + (fcnt % 256)) % 8;
`endif
        b = 3'(x / 2);
        case (mode_l)
            2'd0:    c = 8'hFF;
            2'd1:    c = {b, 5'b0};
            2'd2:    c = bars_tab[x];
            default: c = ((((x >> 1) ^ (v >> 1)) & 1) != 0) ? 8'hFF : 8'h00;
        endcase
        return inv_l ? ~c : c;
    endfunction

    // One pixel of the small instance; the model latches switches at (0,0) and counts frames at the wrap.
    task automatic step_s();
        logic [3:0] sw_at;
        sw_at = sw_s;
        @(posedge clk);
        @(negedge clk);
        p = (p + 1) % 84;
        if (p == 0) begin
            mode_l = sw_at[1:0];
            inv_l  = sw_at[2];
            frz_l  = sw_at[3];
        end
        if (p == 83 && !frz_l) fcnt = (fcnt + 1) % 65536;
    endtask

    task automatic check_pix();
        int h, v;
        h = p % 12;
        v = p / 12;
        check_eq($sformatf("rgb p%0d", p), 32'({red_s, grn_s, blu_s}), 32'(exp_rgb(h, v)));
        check_eq($sformatf("de p%0d", p), 32'(de_s), 32'(h < 8 && v < 4));
        check_eq($sformatf("hs p%0d", p), 32'(hs_s), 32'(!(h == 9 || h == 10)));
        check_eq($sformatf("vs p%0d", p), 32'(vs_s), 32'(v != 5));
        check_eq($sformatf("fs p%0d", p), 32'(fs_s), 32'(p == 0));
    endtask

    task automatic run_frame(input int chg_at, input logic [3:0] sw_new);
        int fs;
        fs = 0;
        for (int i = 0; i < 84; i++) begin
            step_s();
            if (p == 0) check_eq("led_frame", 32'(led_s), 32'(fcnt % 256));
            check_pix();
            if (fs_s) fs++;
            if (p == chg_at) sw_s = sw_new;
        end
        check_eq("fs_per_frame", 32'(fs), 32'd1);
    endtask

    task automatic check_reset_s(input string tag);
        check_eq({tag, "_rgb"}, 32'({red_s, grn_s, blu_s}), 32'd0);
        check_eq({tag, "_hs"}, 32'(hs_s), 32'd1);
        check_eq({tag, "_vs"}, 32'(vs_s), 32'd1);
        check_eq({tag, "_de"}, 32'(de_s), 32'd0);
        check_eq({tag, "_fs"}, 32'(fs_s), 32'd0);
        check_eq({tag, "_led"}, 32'(led_s), 32'd0);
    endtask

    initial begin
        int n, m, k;
        n_chk = 0; n_bad = 0;
        p = 83; fcnt = 0; mode_l = 2'd0; inv_l = 1'b0; frz_l = 1'b0;
        rst_d = 1'b1; rst_s = 1'b1; sw_d = 4'h0; sw_s = 4'h2;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check_eq("d_rst_hs", 32'(hs_d), 32'd1);
        check_eq("d_rst_vs", 32'(vs_d), 32'd1);
        check_eq("d_rst_rgb", 32'({red_d, grn_d, blu_d}), 32'd0);
        check_eq("d_rst_led", 32'(led_d), 32'd0);
        check_eq("d_rst_fs_de", 32'({fs_d, de_d}), 32'd0);
        check_reset_s("s_rst");

        // Default 640x480 timing: first h_sync fall, its width and the line period.
        rst_d = 1'b0;
        n = 0;
        while (hs_d === 1'b1 && n < 5000) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (n == 2) begin
                check_eq("d_first_pix_rgb", 32'({red_d, grn_d, blu_d}), 32'hFF);
                check_eq("d_first_pix_de", 32'(de_d), 32'd1);
            end
        end
        check_eq("d_hs_first_fall", 32'(n), 32'd1314);
        m = 0;
        while (hs_d === 1'b0 && m < 5000) begin
            @(posedge clk); @(negedge clk);
            m++;
        end
        check_eq("d_hs_width", 32'(m), 32'd192);
        k = 0;
        while (hs_d === 1'b1 && k < 5000) begin
            @(posedge clk); @(negedge clk);
            k++;
        end
        check_eq("d_line_period", 32'(m + k), 32'd1600);
        check_eq("d_vs_line0", 32'(vs_d), 32'd1);
        rst_d = 1'b1;

        // Small timing: bars, mid-frame switch to checker, inverted bars, then freeze.
        rst_s = 1'b0;
        run_frame(30, 4'h3);
        run_frame(20, 4'h6);
        run_frame(40, 4'hB);
        run_frame(-1, 4'h0);
        check_eq("led_frozen_f3", 32'(led_s), 32'd3);
        run_frame(-1, 4'h0);
        check_eq("led_frozen_f4", 32'(led_s), 32'd3);
        run_frame(10, 4'h1);
        check_eq("led_frozen_f5", 32'(led_s), 32'd3);
        run_frame(-1, 4'h0);
        check_eq("led_run_f6", 32'(led_s), 32'd4);
        run_frame(50, 4'h0);
        check_eq("led_run_f7", 32'(led_s), 32'd5);

        // Reset while the counters sit at (5,2), then a clean white frame from (0,0).
        while (p != 28) begin
            step_s();
            check_pix();
        end
        rst_s = 1'b1;
        @(posedge clk); @(negedge clk);
        check_reset_s("s_midrst");
        rst_s = 1'b0;
        p = 83; fcnt = 0; mode_l = 2'd0; inv_l = 1'b0; frz_l = 1'b0;
        run_frame(-1, 4'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
